axi4read_seq: RTL and testbench
===============================

Name: axi4read_seq

Overview:
- Command-driven sequencer directly upstream of the single-transaction AXI4 two-beat reader (`axi4read`, the block that returns 2×DATA_WIDTH per operation).
- Takes a base address and an entry count, issues one reader operation per entry at BASE + i*STRIDE, and forwards each 2×DATA_WIDTH result on a valid/ready stream.
- Flags the end of the sequence and aborts on the first bad read response.
- One operation outstanding at a time; single-entry output register.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, byte address width; matches the reader.
- C_M_AXI_DATA_WIDTH, 64, reader beat width; each entry is 2*C_M_AXI_DATA_WIDTH bits.
- COUNT_WIDTH, 16, width of the entry count and progress counter.
- STRIDE, 16, byte increment between consecutive entry addresses.

Ports:
- ACLK  in  1  clock; the only clock.
- ARESET  in  1  reset, synchronous and active-high. The reader instance is driven with ARESETN = ~ARESET.
- CMD_START  in  1  start request; sampled only in ST_IDLE.
- CMD_BASE  in  C_M_AXI_ADDR_WIDTH  first entry address; captured on accepted start.
- CMD_COUNT  in  COUNT_WIDTH  number of entries; captured on accepted start.
- CMD_BUSY  out  1  high from the cycle after an accepted start until CMD_DONE.
- CMD_DONE  out  1  one-cycle pulse at sequence end (normal, error, or zero count).
- CMD_ERR  out  1  sticky error flag; valid with CMD_DONE, held until next accepted start.
- CMD_NDONE  out  COUNT_WIDTH  number of entries delivered on the stream so far.
- RD_START  out  1  to reader OP_START.
- RD_ADDRESS  out  C_M_AXI_ADDR_WIDTH  to reader ADDRESS.
- RD_DONE  in  1  from reader OP_DONE; one-cycle pulse.
- RD_OK  in  1  from reader OP_OK; valid in the RD_DONE cycle.
- RD_VAL  in  2*C_M_AXI_DATA_WIDTH  from reader RET_VAL; valid in the RD_DONE cycle.
- M_TDATA  out  2*C_M_AXI_DATA_WIDTH  entry data.
- M_TVALID  out  1  entry valid.
- M_TREADY  in  1  consumer ready.
- M_TLAST  out  1  high with the final entry of the sequence.

Behaviour:
- Reset: all outputs 0, state ST_IDLE. Reset mid-operation abandons the sequence with no CMD_DONE. The reader is reset by the same signal.
- All outputs are registered. States are ST_IDLE, ST_ISSUE, ST_PUSH and ST_END.
- ST_IDLE, CMD_START=1 at edge t:
  - Capture CMD_BASE, CMD_COUNT; clear CMD_ERR and CMD_NDONE; set CMD_BUSY.
  - Count 0: go to ST_END.
  - Count nonzero: go to ST_ISSUE, with RD_START=1 and RD_ADDRESS=BASE from cycle t+1.
- ST_ISSUE:
  - RD_START is held high continuously. This covers the reader's post-reset idle cycle.
  - RD_ADDRESS is held stable until RD_DONE.
  - At the edge where RD_DONE=1, RD_START goes to 0, so the reader sees it low when it returns to its start-wait state.
  - RD_OK=1: load M_TDATA=RD_VAL, M_TVALID=1, M_TLAST=(index==COUNT-1); go to ST_PUSH.
  - RD_OK=0: CMD_ERR=1, nothing pushed; go to ST_END.
- ST_PUSH:
  - M_TDATA, M_TVALID and M_TLAST are held until M_TREADY=1.
  - On the handshake: M_TVALID=0, CMD_NDONE+1, index+1.
  - If the entry was last, go to ST_END.
  - Otherwise go to ST_ISSUE with RD_ADDRESS += STRIDE; RD_START is high the next cycle (one idle cycle between ops minimum).
- ST_END: CMD_DONE=1 for exactly one cycle, CMD_BUSY=0 on the same cycle; return to ST_IDLE. A new start is accepted the next cycle.
- CMD_START while busy is ignored; no queuing.
- Address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH. Index and count are unsigned COUNT_WIDTH.
- RD_DONE outside ST_ISSUE is ignored (protocol violation; must not corrupt state).
- A new read is never issued while M_TVALID=1, so RD_VAL always has a free output slot.

Test Plan:
- BASE=0x1000, COUNT=3, TREADY=1, reader OK:
  - RD_ADDRESS sequence 0x1000, 0x1010, 0x1020.
  - 3 stream beats, M_TLAST only on the 3rd.
  - CMD_NDONE=3, one CMD_DONE pulse, CMD_ERR=0.
- COUNT=2 with TREADY low for 5 cycles on entry 0:
  - M_TDATA/M_TVALID held unchanged for those cycles.
  - RD_START stays low until the handshake.
  - Both entries delivered in order.
- COUNT=4, reader returns RD_OK=0 on entry 1:
  - Entry 0 delivered; no further beats or reads.
  - CMD_ERR=1 with CMD_DONE; CMD_NDONE=1.
- COUNT=0:
  - CMD_DONE pulses 2 cycles after start.
  - RD_START never asserts, no stream beats.
- CMD_START pulsed again mid-sequence with a different BASE: ignored; addresses follow the original BASE.
- Address wrap and reset:
  - BASE=0xFFFF_FFFF_FFFF_FFF0, COUNT=2 gives second address 0x0.
  - Assert ARESET during ST_ISSUE: all outputs 0 next cycle, then a fresh COUNT=1 sequence completes normally.

Source files
------------

// File: rtl/axi4read_seq.sv
// axi4read_seq: walks BASE + i*STRIDE for COUNT entries through the two-beat
// AXI4 reader and forwards each 2*DATA_WIDTH result on a valid/ready stream.
module axi4read_seq #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
    parameter int unsigned COUNT_WIDTH        = 16,
    parameter int unsigned STRIDE             = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              CMD_START,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_BASE,
    input  logic [COUNT_WIDTH-1:0]            CMD_COUNT,
    output logic                              CMD_BUSY,
    output logic                              CMD_DONE,
    output logic                              CMD_ERR,
    output logic [COUNT_WIDTH-1:0]            CMD_NDONE,
    output logic                              RD_START,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     RD_ADDRESS,
    input  logic                              RD_DONE,
    input  logic                              RD_OK,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   RD_VAL,
    output logic [2*C_M_AXI_DATA_WIDTH-1:0]   M_TDATA,
    output logic                              M_TVALID,
    input  logic                              M_TREADY,
    output logic                              M_TLAST
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned EW = 2 * C_M_AXI_DATA_WIDTH;
    localparam int unsigned CW = COUNT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_PUSH  = 2'd2,
        ST_END   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;
    logic [CW-1:0] ndone_q,    ndone_d;
    logic          rd_start_q, rd_start_d;
    logic [AW-1:0] rd_addr_q,  rd_addr_d;
    logic [EW-1:0] tdata_q,    tdata_d;
    logic          tvalid_q,   tvalid_d;
    logic          tlast_q,    tlast_d;
    logic [CW-1:0] count_q,    count_d;
    logic [CW-1:0] idx_q,      idx_d;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (CMD_START) state_d = (CMD_COUNT == '0) ? ST_END : ST_ISSUE;
            ST_ISSUE: if (RD_DONE)   state_d = RD_OK ? ST_PUSH : ST_END;
            ST_PUSH:  if (M_TREADY)  state_d = tlast_q ? ST_END : ST_ISSUE;
            ST_END:                  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and sequence bookkeeping
    always_comb begin
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        ndone_d    = ndone_q;
        rd_start_d = rd_start_q;
        rd_addr_d  = rd_addr_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        count_d    = count_q;
        idx_d      = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (CMD_START) begin
                    count_d    = CMD_COUNT;
                    idx_d      = '0;
                    err_d      = 1'b0;
                    ndone_d    = '0;
                    busy_d     = 1'b1;
                    rd_addr_d  = CMD_BASE;
                    rd_start_d = (CMD_COUNT != '0);
                end
            end
            ST_ISSUE: begin
                // Drop start on the completion edge so the reader sees it low on return
                if (RD_DONE) begin
                    rd_start_d = 1'b0;
                    if (RD_OK) begin
                        tdata_d  = RD_VAL;
                        tvalid_d = 1'b1;
                        tlast_d  = (idx_q == count_q - CW'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PUSH: begin
                if (M_TREADY) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    ndone_d  = ndone_q + CW'(1);
                    idx_d    = idx_q + CW'(1);
                    if (!tlast_q) begin
                        rd_addr_d  = rd_addr_q + AW'(STRIDE);
                        rd_start_d = 1'b1;
                    end
                end
            end
            ST_END: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ndone_q    <= '0;
            rd_start_q <= 1'b0;
            rd_addr_q  <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            count_q    <= '0;
            idx_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ndone_q    <= ndone_d;
            rd_start_q <= rd_start_d;
            rd_addr_q  <= rd_addr_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
        end
    end

    assign CMD_BUSY   = busy_q;
    assign CMD_DONE   = done_q;
    assign CMD_ERR    = err_q;
    assign CMD_NDONE  = ndone_q;
    assign RD_START   = rd_start_q;
    assign RD_ADDRESS = rd_addr_q;
    assign M_TDATA    = tdata_q;
    assign M_TVALID   = tvalid_q;
    assign M_TLAST    = tlast_q;

endmodule

// File: tb/tb_axi4read_seq.sv
// tb_axi4read_seq: bench for axi4read_seq with a behavioural reader and a
// stream scoreboard fed from the commanded base/count.
module tb_axi4read_seq;

    localparam int unsigned AW = 64;
    localparam int unsigned EW = 128;
    localparam int unsigned CW = 16;
    localparam int unsigned STRIDE = 16;

    typedef struct packed {
        logic [EW-1:0] data;
        logic          last;
    } beat_t;

    logic          ACLK;
    logic          ARESET;
    logic          CMD_START;
    logic [AW-1:0] CMD_BASE;
    logic [CW-1:0] CMD_COUNT;
    logic          CMD_BUSY;
    logic          CMD_DONE;
    logic          CMD_ERR;
    logic [CW-1:0] CMD_NDONE;
    logic          RD_START;
    logic [AW-1:0] RD_ADDRESS;
    logic          RD_DONE;
    logic          RD_OK;
    logic [EW-1:0] RD_VAL;
    logic [EW-1:0] M_TDATA;
    logic          M_TVALID;
    logic          M_TREADY;
    logic          M_TLAST;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr_q[$];
    beat_t         exp_beat_q[$];
    int            rd_fail_idx = -1;
    int            seq_op = 0;
    int            rd_count = 0;
    int            beat_count = 0;

    axi4read_seq #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(EW / 2),
        .COUNT_WIDTH(CW),
        .STRIDE(STRIDE)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .CMD_START(CMD_START),
        .CMD_BASE(CMD_BASE),
        .CMD_COUNT(CMD_COUNT),
        .CMD_BUSY(CMD_BUSY),
        .CMD_DONE(CMD_DONE),
        .CMD_ERR(CMD_ERR),
        .CMD_NDONE(CMD_NDONE),
        .RD_START(RD_START),
        .RD_ADDRESS(RD_ADDRESS),
        .RD_DONE(RD_DONE),
        .RD_OK(RD_OK),
        .RD_VAL(RD_VAL),
        .M_TDATA(M_TDATA),
        .M_TVALID(M_TVALID),
        .M_TREADY(M_TREADY),
        .M_TLAST(M_TLAST)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [EW-1:0] data_of(input logic [AW-1:0] a);
        return {~a, a ^ 64'hA5A5_5A5A_0F0F_F0F0};
    endfunction

    // Behavioural two-beat reader: variable latency, optional failing op
    initial begin : reader_model
        logic          active;
        int            wait_cnt;
        logic [AW-1:0] lat_addr;
        logic [AW-1:0] ea;
        active = 1'b0;
        wait_cnt = 0;
        lat_addr = '0;
        RD_DONE = 1'b0;
        RD_OK = 1'b0;
        RD_VAL = '0;
        forever begin
            @(posedge ACLK); #1;
            RD_DONE = 1'b0;
            if (ARESET) begin
                active = 1'b0;
            end else if (active) begin
                checks++;
                if (RD_ADDRESS !== lat_addr || RD_START !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_hold addr=%h start=%b required addr=%h start=1", RD_ADDRESS, RD_START, lat_addr);
                end
                if (wait_cnt == 0) begin
                    RD_DONE = 1'b1;
                    RD_OK = (seq_op != rd_fail_idx);
                    RD_VAL = data_of(lat_addr);
                    seq_op++;
                    active = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (RD_START === 1'b1) begin
                rd_count++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected addr=%h required no read", RD_ADDRESS);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (RD_ADDRESS !== ea) begin
                        errors++;
                        $display("FAIL rd_address got=%h required=%h", RD_ADDRESS, ea);
                    end
                end
                lat_addr = RD_ADDRESS;
                active = 1'b1;
                wait_cnt = $urandom_range(0, 2);
            end
        end
    end

    // Stream monitor: handshakes sampled mid-cycle against the scoreboard
    initial begin : stream_monitor
        beat_t eb;
        forever begin
            @(negedge ACLK);
            if (!ARESET && M_TVALID === 1'b1) begin
                checks++;
                if (RD_START !== 1'b0) begin
                    errors++;
                    $display("FAIL read_while_valid rd_start=%b required=0", RD_START);
                end
                if (M_TREADY === 1'b1) begin
                    beat_count++;
                    checks++;
                    if (exp_beat_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected data=%h last=%b required no beat", M_TDATA, M_TLAST);
                    end else begin
                        eb = exp_beat_q.pop_front();
                        if (M_TDATA !== eb.data || M_TLAST !== eb.last) begin
                            errors++;
                            $display("FAIL beat got=%h/%b required=%h/%b", M_TDATA, M_TLAST, eb.data, eb.last);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    // Pulse a command and load the expected reads/beats it should produce
    task automatic start_cmd(input logic [AW-1:0] base, input int count, input int fail_idx);
        int n_rd;
        int n_bt;
        beat_t b;
        logic [AW-1:0] a;
        n_rd = (fail_idx >= 0 && fail_idx < count) ? fail_idx + 1 : count;
        n_bt = (fail_idx >= 0 && fail_idx < count) ? fail_idx : count;
        rd_fail_idx = fail_idx;
        seq_op = 0;
        for (int i = 0; i < n_rd; i++) begin
            a = base + AW'(i) * AW'(STRIDE);
            exp_addr_q.push_back(a);
            if (i < n_bt) begin
                b.data = data_of(a);
                b.last = (i == count - 1);
                exp_beat_q.push_back(b);
            end
        end
        CMD_START = 1'b1;
        CMD_BASE = base;
        CMD_COUNT = CW'(count);
        @(posedge ACLK); #1;
        CMD_START = 1'b0;
    endtask

    // Wait for CMD_DONE; cycles counts from the start-pulse cycle
    task automatic wait_done(output int cycles, output bit tmo);
        cycles = 1;
        tmo = 1'b0;
        while (CMD_DONE !== 1'b1) begin
            if (cycles >= 3000) begin
                tmo = 1'b1;
                break;
            end
            @(posedge ACLK); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({CMD_BUSY, CMD_DONE, CMD_ERR, RD_START, M_TVALID, M_TLAST} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required=000000", {CMD_BUSY, CMD_DONE, CMD_ERR, RD_START, M_TVALID, M_TLAST});
        end
        checks++;
        if (CMD_NDONE !== '0) begin errors++; $display("FAIL reset_ndone got=%0d required=0", CMD_NDONE); end
        checks++;
        if (RD_ADDRESS !== '0) begin errors++; $display("FAIL reset_addr got=%h required=0", RD_ADDRESS); end
        checks++;
        if (M_TDATA !== '0) begin errors++; $display("FAIL reset_tdata got=%h required=0", M_TDATA); end
        ARESET = 1'b0;
        @(posedge ACLK); #1;
    endtask

    task automatic test_basic();
        int cyc; bit tmo; int rd0; int bt0;
        rd0 = rd_count; bt0 = beat_count;
        start_cmd(64'h1000, 3, -1);
        checks++;
        if (CMD_BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b required=1", CMD_BUSY); end
        wait_done(cyc, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL basic_done_timeout got=none required=CMD_DONE"); end
        checks++;
        if (CMD_BUSY !== 1'b0 || CMD_ERR !== 1'b0 || CMD_NDONE !== 16'd3) begin
            errors++;
            $display("FAIL basic_status got busy=%b err=%b ndone=%0d required 0/0/3", CMD_BUSY, CMD_ERR, CMD_NDONE);
        end
        checks++;
        if (rd_count - rd0 != 3 || beat_count - bt0 != 3) begin
            errors++;
            $display("FAIL basic_counts got reads=%0d beats=%0d required 3/3", rd_count - rd0, beat_count - bt0);
        end
        @(posedge ACLK); #1;
        checks++;
        if (CMD_DONE !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b required=0", CMD_DONE); end
    endtask

    task automatic test_backpressure();
        int cyc; bit tmo; logic [EW-1:0] d0; int n;
        M_TREADY = 1'b0;
        start_cmd(64'h3000, 2, -1);
        n = 0;
        while (M_TVALID !== 1'b1 && n < 200) begin
            @(posedge ACLK); #1;
            n++;
        end
        checks++;
        if (M_TVALID !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got=%b required=1", M_TVALID); end
        d0 = M_TDATA;
        checks++;
        if (d0 !== data_of(64'h3000)) begin errors++; $display("FAIL bp_data0 got=%h required=%h", d0, data_of(64'h3000)); end
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK); #1;
            checks++;
            if (M_TVALID !== 1'b1 || M_TDATA !== d0 || RD_START !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got valid=%b start=%b data=%h required 1/0/%h", i, M_TVALID, RD_START, M_TDATA, d0);
            end
        end
        M_TREADY = 1'b1;
        wait_done(cyc, tmo);
        checks++;
        if (tmo || CMD_NDONE !== 16'd2 || CMD_ERR !== 1'b0) begin
            errors++;
            $display("FAIL bp_status got tmo=%b ndone=%0d err=%b required 0/2/0", tmo, CMD_NDONE, CMD_ERR);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_error();
        int cyc; bit tmo; int rd0; int bt0;
        rd0 = rd_count; bt0 = beat_count;
        start_cmd(64'h4000, 4, 1);
        wait_done(cyc, tmo);
        checks++;
        if (tmo || CMD_ERR !== 1'b1 || CMD_NDONE !== 16'd1) begin
            errors++;
            $display("FAIL err_status got tmo=%b err=%b ndone=%0d required 0/1/1", tmo, CMD_ERR, CMD_NDONE);
        end
        repeat (6) @(posedge ACLK);
        #1;
        checks++;
        if (rd_count - rd0 != 2 || beat_count - bt0 != 1) begin
            errors++;
            $display("FAIL err_counts got reads=%0d beats=%0d required 2/1", rd_count - rd0, beat_count - bt0);
        end
        checks++;
        if (CMD_ERR !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b required=1", CMD_ERR); end
        rd_fail_idx = -1;
    endtask

    task automatic test_zero();
        int cyc; bit tmo; int rd0; int bt0;
        rd0 = rd_count; bt0 = beat_count;
        start_cmd(64'h7000, 0, -1);
        checks++;
        if (CMD_ERR !== 1'b0) begin errors++; $display("FAIL zero_err_clear got=%b required=0", CMD_ERR); end
        wait_done(cyc, tmo);
        checks++;
        if (tmo || cyc != 2) begin errors++; $display("FAIL zero_done_latency got=%0d tmo=%b required=2", cyc, tmo); end
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if (rd_count != rd0 || beat_count != bt0 || CMD_NDONE !== '0) begin
            errors++;
            $display("FAIL zero_activity got reads=%0d beats=%0d ndone=%0d required 0/0/0", rd_count - rd0, beat_count - bt0, CMD_NDONE);
        end
    endtask

    task automatic test_restart_ignored();
        int cyc; bit tmo;
        start_cmd(64'h2000, 3, -1);
        repeat (2) @(posedge ACLK);
        #1;
        CMD_START = 1'b1;
        CMD_BASE = 64'h9000;
        CMD_COUNT = 16'd5;
        @(posedge ACLK); #1;
        CMD_START = 1'b0;
        wait_done(cyc, tmo);
        checks++;
        if (tmo || CMD_NDONE !== 16'd3) begin
            errors++;
            $display("FAIL restart_ndone got=%0d tmo=%b required=3", CMD_NDONE, tmo);
        end
        repeat (4) @(posedge ACLK);
        #1;
        checks++;
        if (CMD_BUSY !== 1'b0) begin errors++; $display("FAIL restart_idle got busy=%b required=0", CMD_BUSY); end
    endtask

    task automatic test_wrap();
        int cyc; bit tmo;
        start_cmd(64'hFFFF_FFFF_FFFF_FFF0, 2, -1);
        checks++;
        if (exp_addr_q.size() < 1 || exp_addr_q[exp_addr_q.size()-1] !== 64'h0) begin
            errors++;
            $display("FAIL wrap_model got second addr not 0 required=0");
        end
        wait_done(cyc, tmo);
        checks++;
        if (tmo || CMD_NDONE !== 16'd2) begin errors++; $display("FAIL wrap_ndone got=%0d tmo=%b required=2", CMD_NDONE, tmo); end
        @(posedge ACLK); #1;
    endtask

    task automatic test_reset_mid();
        int cyc; bit tmo; beat_t b;
        start_cmd(64'h5000, 3, -1);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        checks++;
        if ({CMD_BUSY, CMD_DONE, CMD_ERR, RD_START, M_TVALID, M_TLAST} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_flags got=%b required=000000", {CMD_BUSY, CMD_DONE, CMD_ERR, RD_START, M_TVALID, M_TLAST});
        end
        checks++;
        if (CMD_NDONE !== '0 || RD_ADDRESS !== '0 || M_TDATA !== '0) begin
            errors++;
            $display("FAIL rstmid_regs got ndone=%0d addr=%h data=%h required 0", CMD_NDONE, RD_ADDRESS, M_TDATA);
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        @(posedge ACLK); #1;
        checks++;
        if (CMD_DONE !== 1'b0 || CMD_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done got done=%b busy=%b required 0/0", CMD_DONE, CMD_BUSY);
        end
        start_cmd(64'h6000, 1, -1);
        wait_done(cyc, tmo);
        checks++;
        if (tmo || CMD_NDONE !== 16'd1 || CMD_ERR !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_fresh got tmo=%b ndone=%0d err=%b required 0/1/0", tmo, CMD_NDONE, CMD_ERR);
        end
        b = '0;
        @(posedge ACLK); #1;
    endtask

    initial begin : main
        ARESET = 1'b1;
        CMD_START = 1'b0;
        CMD_BASE = '0;
        CMD_COUNT = '0;
        M_TREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_error();
        test_zero();
        test_restart_ignored();
        test_wrap();
        test_reset_mid();
        repeat (4) @(posedge ACLK);
        #1;
        checks++;
        if (exp_addr_q.size() != 0 || exp_beat_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got reads=%0d beats=%0d required 0/0", exp_addr_q.size(), exp_beat_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
